// File: rtl/llama_fifo_pkg.sv
// Shared FIFO constants and the pointer-width derivation used by flow_fifo and its storage.
package llama_fifo_pkg;

  localparam int DEFAULT_D_WIDTH    = 32;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // One extra MSB beyond the index bits tells full apart from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flow_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port, never reset.
module flow_fifo_mem #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/flow_fifo.sv
// First-word-fall-through FIFO with registered occupancy count, threshold flags and high-water mark.
module flow_fifo
  import llama_fifo_pkg::*;
#(
  parameter int D_WIDTH    = DEFAULT_D_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [D_WIDTH-1:0]           in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [D_WIDTH-1:0]           out_data,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]  high_water
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0]      count_reg, count_next;
  logic [PW-1:0]      hw_reg;
  logic               full, empty, push, pop;
  logic [D_WIDTH-1:0] rd_data;

  // Same index with differing MSB means the writer has lapped the reader once.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + ONE;
      2'b01:   count_next = count_reg - ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hw_reg     <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hw_reg     <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + ONE;
      count_reg <= count_next;
      if (count_next > hw_reg) hw_reg <= count_next;
    end
  end

  flow_fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (FIFO_DEPTH),
    .AW      (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  // Storage is never reset, so mask the read port until an entry is really present.
  assign out_data     = out_valid ? rd_data : '0;
  assign count        = count_reg;
  assign high_water   = hw_reg;
  assign almost_full  = (count_reg >= AF_THRESH);
  assign almost_empty = (count_reg <= AE_THRESH);

endmodule

// File: tb/tb_flow_fifo.sv
// Scoreboard bench for flow_fifo at depth 4: stimulus queues expected words, a monitor checks every pop.
module tb_flow_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] high_water;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int m_cnt = 0;
  int m_hw  = 0;

  always #5 clk = ~clk;

  flow_fifo #(
    .D_WIDTH    (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .high_water   (high_water)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop is about to happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", out_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("pop_data", int'(out_data), int'(e));
        $display("pop  data=0x%02h expected=0x%02h", out_data, e);
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, ".count"}, int'(count), m_cnt);
    check({tag, ".in_ready"}, int'(in_ready), int'(m_cnt != DEPTH));
    check({tag, ".out_valid"}, int'(out_valid), int'(m_cnt != 0));
    check({tag, ".almost_full"}, int'(almost_full), int'(m_cnt >= DEPTH - 2));
    check({tag, ".almost_empty"}, int'(almost_empty), int'(m_cnt <= 2));
    check({tag, ".high_water"}, int'(high_water), m_hw);
    if (m_cnt == 0) check({tag, ".out_data_zero"}, int'(out_data), 0);
    else            check({tag, ".out_data_head"}, int'(out_data), int'(exp_q[0]));
  endtask

  // One clock of stimulus; the model mirrors the protocol rules, not the RTL.
  task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    bit push_ok, pop_ok;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    push_ok = iv && (m_cnt != DEPTH);
    pop_ok  = ordy && (m_cnt != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_cnt = 0;
      m_hw  = 0;
    end else begin
      if (push_ok) exp_q.push_back(d);
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
      if (m_cnt > m_hw) m_hw = m_cnt;
    end
    $display("cyc  %s iv=%0b d=0x%02h ordy=%0b flush=%0b -> count=%0d", tag, iv, d, ordy, fl, count);
    check_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, int'(in_ready), 1);
    check({tag, ".out_valid"}, int'(out_valid), 0);
    check({tag, ".out_data"}, int'(out_data), 0);
    check({tag, ".count"}, int'(count), 0);
    check({tag, ".almost_full"}, int'(almost_full), 0);
    check({tag, ".almost_empty"}, int'(almost_empty), 1);
    check({tag, ".high_water"}, int'(high_water), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Fill to full, then offer a fifth word that must be dropped
    cycle("fill1", 1'b1, 8'hA1, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 8'hA2, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 8'hA3, 1'b0, 1'b0);
    cycle("fill4", 1'b1, 8'hA4, 1'b0, 1'b0);
    cycle("over",  1'b1, 8'hA5, 1'b0, 1'b0);

    // Full with pop and push offered: pop wins, push rejected
    cycle("fullpp", 1'b1, 8'hA6, 1'b1, 1'b0);
    cycle("drain1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

    // Single word into empty FIFO
    cycle("one",    1'b1, 8'h55, 1'b0, 1'b0);
    cycle("hold",   1'b0, 8'h00, 1'b0, 1'b0);
    cycle("popone", 1'b0, 8'h00, 1'b1, 1'b0);

    // Steady push+pop at count 2 across several pointer wraps
    cycle("pre1", 1'b1, 8'h10, 1'b0, 1'b0);
    cycle("pre2", 1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle("stream", 1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
    end
    cycle("sdrain1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("sdrain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 3 with a push offered
    cycle("f1", 1'b1, 8'h31, 1'b0, 1'b0);
    cycle("f2", 1'b1, 8'h32, 1'b0, 1'b0);
    cycle("f3", 1'b1, 8'h33, 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h34, 1'b1, 1'b1);
    cycle("pflush", 1'b1, 8'h40, 1'b0, 1'b0);
    cycle("pflush2", 1'b1, 8'h41, 1'b0, 1'b0);

    // Asynchronous reset between clock edges with data in flight
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_cnt = 0;
    m_hw  = 0;
    $display("rst  asserted mid-cycle");
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First push after reset behaves as into an empty FIFO
    cycle("post1", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("post2", 1'b1, 8'h78, 1'b1, 1'b0);
    cycle("post3", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle",  1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
